// File: rtl/scroll_ctrl.sv
// Purpose: fetches 16 glyph rows per scroll step from a row ROM and commits them as one atomic 256-bit frame.
// Latency: first frame starts the cycle after enable; a frame commits one cycle after its last row is accepted.
// Backpressure: ROM handshake is req/valid, a stalled ROM holds the fetch; ticks arriving mid-frame are kept one deep.
module scroll_ctrl #(
    parameter int STEP_DIV = 3000000,
    parameter int ROWS     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic                 i_dir,
    input  logic [1:0]           i_speed,
    output logic                 o_rom_req,
    output logic [5:0]           o_rom_addr,
    input  logic                 i_rom_valid,
    input  logic [15:0]          i_rom_data,
    output logic [16*ROWS-1:0]   o_frame,
    output logic                 o_frame_valid,
    output logic [5:0]           o_pos,
    output logic                 o_busy
);

    localparam int CW = $clog2(STEP_DIV + 1);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_COMMIT
    } state_t;

    state_t                  state;
    logic [CW-1:0]           step_cnt;
    logic [CW-1:0]           step_lim;
    logic                    tick;
    logic                    pending;
    logic [5:0]              fetch_pos;
    logic [5:0]              step_pos;
    logic [RW-1:0]           row_idx;
    logic [ROWS-1:0][15:0]   shadow;

    // Step interval limit follows i_speed combinationally so a speed change applies at once.
    always_comb begin
        int lim_i;
        lim_i    = (STEP_DIV >> i_speed) - 1;
        step_lim = lim_i[CW-1:0];
        tick     = i_enable && (step_cnt >= step_lim);
        step_pos = i_dir ? (o_pos - 6'd1) : (o_pos + 6'd1);
    end

    // Step counter: runs only while enabled, wraps to zero on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (!i_enable || tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + CW'(1);
        end
    end

    // Control FSM: fetch rows into the shadow buffer, then publish the whole frame in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pending       <= 1'b0;
            fetch_pos     <= '0;
            row_idx       <= '0;
            shadow        <= '0;
            o_rom_req     <= 1'b0;
            o_rom_addr    <= '0;
            o_frame       <= '0;
            o_frame_valid <= 1'b0;
            o_pos         <= '0;
            o_busy        <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    pending <= 1'b0;
                    if (i_enable) begin
                        // First frame after enable shows the current position, no tick wait.
                        fetch_pos  <= o_pos;
                        o_rom_addr <= o_pos;
                        o_rom_req  <= 1'b1;
                        row_idx    <= '0;
                        o_busy     <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (!i_enable) begin
                        pending <= 1'b0;
                        state   <= S_IDLE;
                    end else if (tick || pending) begin
                        fetch_pos  <= step_pos;
                        o_rom_addr <= step_pos;
                        o_rom_req  <= 1'b1;
                        row_idx    <= '0;
                        pending    <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (tick) begin
                        pending <= 1'b1;
                    end
                    if (i_rom_valid && o_rom_req) begin
                        shadow[row_idx] <= i_rom_data;
                        if (row_idx == RW'(ROWS - 1)) begin
                            o_rom_req <= 1'b0;
                            state     <= S_COMMIT;
                        end else begin
                            row_idx    <= row_idx + RW'(1);
                            o_rom_addr <= o_rom_addr + 6'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (tick) begin
                        pending <= 1'b1;
                    end
                    o_frame       <= shadow;
                    o_pos         <= fetch_pos;
                    o_frame_valid <= 1'b1;
                    o_busy        <= 1'b0;
                    if (i_enable) begin
                        state <= S_WAIT;
                    end else begin
                        // Leaving for IDLE discards any tick that arrived during this frame.
                        pending <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Purpose: scoreboard bench for scroll_ctrl; expected commit positions are queued, a monitor checks each commit.
// Latency: ROM model answers data=addr after a programmable number of cycles per row.
// Backpressure: ROM latency is varied to stall fetches and exercise the one-deep pending tick.
module tb_scroll_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_enable;
    logic         i_dir;
    logic [1:0]   i_speed;
    logic         o_rom_req;
    logic [5:0]   o_rom_addr;
    logic         i_rom_valid;
    logic [15:0]  i_rom_data;
    logic [255:0] o_frame;
    logic         o_frame_valid;
    logic [5:0]   o_pos;
    logic         o_busy;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [5:0]   exp_q[$];
    int           rom_lat = 1;
    bit           spur_en = 1'b0;
    logic [255:0] last_frame = '0;
    logic [5:0]   mon_e;

    always #5 clk = ~clk;

    scroll_ctrl #(.STEP_DIV(8), .ROWS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_dir        (i_dir),
        .i_speed      (i_speed),
        .o_rom_req    (o_rom_req),
        .o_rom_addr   (o_rom_addr),
        .i_rom_valid  (i_rom_valid),
        .i_rom_data   (i_rom_data),
        .o_frame      (o_frame),
        .o_frame_valid(o_frame_valid),
        .o_pos        (o_pos),
        .o_busy       (o_busy)
    );

    function automatic logic [255:0] frame_of(input logic [5:0] pos);
        logic [255:0] f;
        logic [5:0]   a;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            a = pos + 6'(k);
            f[16*k +: 16] = {10'b0, a};
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d commits still outstanding after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_addr(input string name, input logic [5:0] a, input int budget);
        int n;
        n = 0;
        while (!(o_rom_req && o_rom_addr == a) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        n_chk++;
        if (!(o_rom_req && o_rom_addr == a)) begin
            n_fail++;
            $display("FAIL %s: request for addr %0d not seen within %0d cycles (req %0b addr %0d)",
                     name, a, budget, o_rom_req, o_rom_addr);
        end
    endtask

    // ROM model: after each accepted row it drops valid, then answers the new address after rom_lat cycles.
    initial begin
        int wait_cnt;
        wait_cnt    = 0;
        i_rom_valid = 1'b0;
        i_rom_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                i_rom_valid = 1'b0;
                wait_cnt    = 0;
            end else if (i_rom_valid) begin
                i_rom_valid = 1'b0;
                wait_cnt    = 0;
            end else if (o_rom_req) begin
                if (wait_cnt >= rom_lat - 1) begin
                    i_rom_valid = 1'b1;
                    i_rom_data  = {10'b0, o_rom_addr};
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (spur_en) begin
                    i_rom_valid = 1'b1;
                    i_rom_data  = 16'hDEAD;
                end
            end
        end
    end

    // Monitor: every commit pulse pops one expected position; between pulses the frame must not move.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_frame = '0;
        end else if (o_frame_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: pos %0d committed, none expected", o_pos);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_pos", {250'b0, o_pos}, {250'b0, mon_e});
                chk("commit_frame", o_frame, frame_of(mon_e));
            end
            last_frame = o_frame;
        end else begin
            chk("frame_hold", o_frame, last_frame);
        end
    end

    initial begin
        rst_n    = 1'b0;
        i_enable = 1'b0;
        i_dir    = 1'b0;
        i_speed  = 2'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_frame", o_frame, '0);
        chk("rst_pos", {250'b0, o_pos}, '0);
        chk("rst_valid", {255'b0, o_frame_valid}, '0);
        chk("rst_req", {255'b0, o_rom_req}, '0);
        chk("rst_addr", {250'b0, o_rom_addr}, '0);
        chk("rst_busy", {255'b0, o_busy}, '0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Forward scroll through a full wrap, with spurious valids while idle
        spur_en  = 1'b1;
        i_enable = 1'b1;
        for (int i = 0; i < 64; i++) exp_q.push_back(6'(i));
        exp_q.push_back(6'd0);
        wait_empty("fwd_wrap", 4000);

        // Reverse from position 0: wraps back to 63
        i_dir = 1'b1;
        exp_q.push_back(6'd63);
        exp_q.push_back(6'd62);
        wait_empty("reverse", 200);
        i_enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rev_idle_busy", {255'b0, o_busy}, '0);
        chk("rev_idle_req", {255'b0, o_rom_req}, '0);
        chk("rev_idle_cnt", {252'b0, dut.step_cnt}, '0);
        spur_en = 1'b0;

        // Slow ROM with tick every cycle: one pending tick, no overrun
        i_dir    = 1'b0;
        i_speed  = 2'd3;
        rom_lat  = 20;
        exp_q.push_back(6'd62);
        exp_q.push_back(6'd63);
        exp_q.push_back(6'd0);
        i_enable = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        chk("slow_pending", {255'b0, dut.pending}, {255'b0, 1'b1});
        chk("slow_busy", {255'b0, o_busy}, {255'b0, 1'b1});
        wait_empty("slow_rom", 1500);
        i_enable = 1'b0;
        i_speed  = 2'd0;
        rom_lat  = 1;
        repeat (5) @(negedge clk);
        #1;
        chk("slow_idle_busy", {255'b0, o_busy}, '0);

        // Enable dropped at row 7: frame still completes, then idle
        exp_q.push_back(6'd0);
        i_enable = 1'b1;
        wait_addr("drop_row7", 6'd7, 100);
        i_enable = 1'b0;
        wait_empty("drop_commit", 100);
        repeat (3) @(negedge clk);
        #1;
        chk("drop_req", {255'b0, o_rom_req}, '0);
        chk("drop_busy", {255'b0, o_busy}, '0);
        chk("drop_cnt", {252'b0, dut.step_cnt}, '0);
        chk("drop_pending", {255'b0, dut.pending}, '0);
        repeat (30) @(negedge clk);

        // Reset in the middle of a fetch: abandoned, restart from 0
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd2);
        i_enable = 1'b1;
        wait_empty("pre_reset", 300);
        wait_addr("reset_row5", 6'd8, 100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_frame", o_frame, '0);
        chk("mid_rst_pos", {250'b0, o_pos}, '0);
        chk("mid_rst_valid", {255'b0, o_frame_valid}, '0);
        chk("mid_rst_req", {255'b0, o_rom_req}, '0);
        chk("mid_rst_addr", {250'b0, o_rom_addr}, '0);
        chk("mid_rst_busy", {255'b0, o_busy}, '0);
        repeat (2) @(negedge clk);
        #1;
        exp_q.push_back(6'd0);
        rst_n = 1'b1;
        wait_empty("post_reset", 100);
        i_enable = 1'b0;
        repeat (10) @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 3000000: clk cycles per scroll step at speed 0.
REQ-002 Parameter ROWS, default 16: glyph rows per frame, fixed at 16.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_enable  input  1  level; 1 = scrolling runs.
REQ-006 i_dir  input  1  0 = pos increments per step, 1 = pos decrements.
REQ-007 i_speed  input  2  step interval = STEP_DIV >> i_speed cycles.
REQ-008 o_rom_req  output  1  glyph-ROM row request.
REQ-009 o_rom_addr  output  6  glyph-ROM row address.
REQ-010 i_rom_valid  input  1  ROM row data valid for the outstanding request.
REQ-011 i_rom_data  input  16  ROM row data, qualified by i_rom_valid.
REQ-012 o_frame  output  256  committed frame, row k in bits [16k+15:16k].
REQ-013 o_frame_valid  output  1  one-cycle pulse on each frame commit.
REQ-014 o_pos  output  6  scroll position of the committed frame.
REQ-015 o_busy  output  1  1 while the FSM is outside IDLE/WAIT.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, FETCH, COMMIT.
REQ-017 IDLE -> FETCH when i_enable=1; the first frame after enable is fetched immediately with no tick wait.
REQ-018 WAIT -> FETCH on a step tick or a pending tick; WAIT -> IDLE when i_enable=0.
REQ-019 FETCH SHALL fetch rows k=0..15 in order from address (fetch_pos + k) mod 64.
REQ-020 fetch_pos SHALL be o_pos for the first frame after enable; otherwise o_pos+1 mod 64 (i_dir=0) or o_pos-1 mod 64 (i_dir=1), sampled at FETCH entry.
REQ-021 Handshake: o_rom_req high with o_rom_addr stable until a cycle with i_rom_valid=1; i_rom_data captured into a shadow row k in that cycle.
REQ-022 After a valid for row k<15, o_rom_req stays high and o_rom_addr advances to the next row on the following cycle; i_rom_valid while o_rom_req=0 SHALL be ignored.
REQ-023 After the valid for row 15: o_rom_req=0 next cycle, FSM -> COMMIT.
REQ-024 COMMIT (one cycle): o_frame <= shadow (all 256 bits atomically), o_pos <= fetch_pos, o_frame_valid=1 for exactly this cycle; next state WAIT if i_enable=1, else IDLE.
REQ-025 o_frame SHALL never show a partially fetched frame.
REQ-026 Step counter counts only while i_enable=1 and is cleared to 0 while i_enable=0.
REQ-027 Step tick: when counter >= (STEP_DIV >> i_speed) - 1, counter cleared and tick asserted one cycle; a speed change takes effect immediately through this comparison.
REQ-028 A tick during FETCH/COMMIT SHALL set a one-deep pending flag; further ticks are dropped; the pending flag is consumed on entry to FETCH.
REQ-029 i_enable deassert during FETCH SHALL complete the current frame including COMMIT, then go to IDLE; the pending flag is cleared on entering IDLE.
REQ-030 Address arithmetic is 6-bit modulo 64 everywhere; 63+1 = 0, 0-1 = 63.
REQ-031 Stalled ROM (no i_rom_valid) SHALL hold FETCH indefinitely; no timeout.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE, o_frame=0, o_frame_valid=0, o_pos=0, o_rom_req=0, o_rom_addr=0, o_busy=0, step counter=0, pending=0, shadow=0.
REQ-033 Reset mid-FETCH SHALL abandon the fetch with no commit; after release the first frame after enable starts at pos 0.

Verification (bench uses STEP_DIV=8)
REQ-034 Reset, enable=1, ROM returns data=addr with 1-cycle latency -> addresses 0..15, one o_frame_valid pulse, o_pos=0, row k = k.
REQ-035 Steady run, i_dir=0, speed=0 -> commits every 8 cycles plus fetch time when fetch < 8 cycles; o_pos 0,1,2...; at o_pos=63 next commit o_pos=0 with row 0 addr 0, row 1 addr 1.
REQ-036 i_dir=1 from o_pos=0 -> next commit o_pos=63, addresses 63,0,1..14.
REQ-037 ROM latency 20 cycles per row, speed=3 (interval 1) -> exactly one pending tick kept; no back-to-back overrun; o_frame constant between pulses.
REQ-038 i_enable dropped at row 7 of a fetch -> rows 8..15 still fetched, one pulse, then IDLE with o_rom_req=0 and counter=0.
REQ-039 rst_n pulsed low at row 5 of a fetch -> all outputs 0 immediately, no pulse; re-enable fetches from address 0.
